// File: rtl/tank_level_emulator.sv
// rtl/tank_level_emulator.sv - water tank emulator driving five thermometer level sensors
module tank_level_emulator #(
    parameter int STEP_CYCLES = 50_000_000,
    parameter int INIT_LEVEL  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fill_req,
    input  logic       drain_req,
    input  logic       fault_en,
    output logic       sen0,
    output logic       sen1,
    output logic       sen2,
    output logic       sen3,
    output logic       sen4,
    output logic [2:0] level,
    output logic       busy
);
    localparam int             CW       = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(STEP_CYCLES - 1);
    localparam logic [2:0]     LVL_INIT = 3'(INIT_LEVEL);
    localparam logic [2:0]     LVL_TOP  = 3'd5;
    localparam logic [4:0]     SEN_INIT = 5'((32'd1 << INIT_LEVEL) - 32'd1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    level_next;
    logic [4:0]    sen_r, sen_next;
    logic          fill_m, fill_s, drain_m, drain_s, fault_m, fault_s;

    // Two-flop synchronisers for the raw button and switch inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_m  <= 1'b0;
            fill_s  <= 1'b0;
            drain_m <= 1'b0;
            drain_s <= 1'b0;
            fault_m <= 1'b0;
            fault_s <= 1'b0;
        end else begin
            fill_m  <= fill_req;
            fill_s  <= fill_m;
            drain_m <= drain_req;
            drain_s <= drain_m;
            fault_m <= fault_en;
            fault_s <= fault_m;
        end
    end

    // Next state, step counter, level and sensor pattern
    always_comb begin
        state_next = state;
        level_next = level;
        cnt_next   = '0;
        sen_next   = '0;
        case (state)
            IDLE: begin
                if (fill_s && !drain_s && level < LVL_TOP)
                    state_next = FILL;
                else if (drain_s && !fill_s && level > 3'd0)
                    state_next = DRAIN;
            end
            FILL: begin
                if (!fill_s || drain_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_MAX) begin
                    level_next = level + 3'd1;
                    if (level == LVL_TOP - 3'd1)
                        state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (!drain_s || fill_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_MAX) begin
                    level_next = level - 3'd1;
                    if (level == 3'd1)
                        state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        for (int i = 0; i < 5; i++)
            sen_next[i] = (level_next > 3'(i));
        // A lit top sensor over a dark one below (or vice versa) breaks the thermometer code
        if (fault_s)
            sen_next[4] = ~sen_next[4];
    end

    // State, level, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= LVL_INIT;
            sen_r <= SEN_INIT;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            sen_r <= sen_next;
            busy  <= (state_next != IDLE);
        end
    end

    assign sen0 = sen_r[0];
    assign sen1 = sen_r[1];
    assign sen2 = sen_r[2];
    assign sen3 = sen_r[3];
    assign sen4 = sen_r[4];
endmodule
